// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: field widths, hazard FSM states and the opcode table
// used by both the decoder and the hazard/stall controller.
package pipeline_pkg;

    localparam int OPC_W = 4;
    localparam int REG_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SLT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_ADDI = 4'h8,
        OP_LW  = 4'h9,
        OP_SW  = 4'hA,
        OP_BEQ = 4'hB,
        OP_BNE = 4'hC,
        OP_JMP = 4'hD,
        OP_MD  = 4'hE,
        OP_NOP = 4'hF
    } opcode_t;

    localparam logic [OPC_W-1:0] MD_OPCODE = OP_MD;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/stall_cycle_counter.sv
// Saturating 16-bit count of cycles in which the PC was held.
module stall_cycle_counter (
    input  logic        clk,
    input  logic        rest,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (!rest) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubble, taken-branch flush, multi-cycle MD hold.
// Optional stall statistics counter built only when STALL_COUNT_EN is defined.
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic [OPC_W-1:0] ex_opcode,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_freeze,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             md_done,
    output logic [15:0]      stall_cycles
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

    hz_state_t        state;
    logic [CNT_W-1:0] md_cnt;
    logic             md_in_ex;
    logic             load_use;

    assign md_in_ex = ex_valid && (ex_opcode == MD_OPCODE);
    // Register 0 never carries a dependency, so a load into it needs no stall.
    assign load_use = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (!rest) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!ex_branch_taken && md_in_ex) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt > CNT_W'(1)) begin
                        md_cnt <= md_cnt - CNT_W'(1);
                    end else begin
                        md_cnt <= '0;
                        state  <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_freeze  = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        md_done      = 1'b0;
        if (!rest) begin
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (md_in_ex) begin
                        pc_freeze    = 1'b1;
                        ifid_freeze  = 1'b1;
                        idex_freeze  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_freeze   = 1'b1;
                        ifid_freeze = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                // EX is owned by the MD op here, so branch and load-use inputs are ignored.
                MD_BUSY: begin
                    if (md_cnt > CNT_W'(1)) begin
                        pc_freeze    = 1'b1;
                        ifid_freeze  = 1'b1;
                        idex_freeze  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (md_cnt == CNT_W'(1)) begin
                        md_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STALL_COUNT_EN
    stall_cycle_counter u_stall_cnt (
        .clk   (clk),
        .rest  (rest),
        .inc   (pc_freeze),
        .count (stall_cycles)
    );
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: expected outputs queued per driven cycle.
module tb_hazard_stall_ctrl;

    localparam int MDC = 4;

    logic        clk = 1'b0;
    logic        rest;
    logic        id_valid;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic        ex_mem_read;
    logic [3:0]  ex_rt;
    logic        ex_branch_taken;
    logic        pc_freeze;
    logic        ifid_freeze;
    logic        ifid_flush;
    logic        idex_freeze;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic        md_done;
    logic [15:0] stall_cycles;

    hazard_stall_ctrl #(.MD_CYCLES(MDC)) dut (
        .clk             (clk),
        .rest            (rest),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_freeze       (pc_freeze),
        .ifid_freeze     (ifid_freeze),
        .ifid_flush      (ifid_flush),
        .idex_freeze     (idex_freeze),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .md_done         (md_done),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [6:0]  outs;
        logic [15:0] cnt;
        logic        cnt_valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_left   = 0;
    int   m_stall  = 0;

    // Output vector order: pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_bubble, exmem_bubble, md_done
    localparam logic [6:0] O_RST  = 7'b0000110;
    localparam logic [6:0] O_MDF  = 7'b1101010;
    localparam logic [6:0] O_DONE = 7'b0000001;
    localparam logic [6:0] O_BR   = 7'b0010100;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_NONE = 7'b0000000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic idv, input logic [3:0] rs,
                       input logic [3:0] rt, input logic urt, input logic exv, input logic [3:0] opc,
                       input logic mr, input logic [3:0] ert, input logic br);
        exp_t e;
        int   nl;
        int   ns;
        logic lu;
        exp_t got;
        @(negedge clk);
        rest = r; id_valid = idv; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_valid = exv; ex_opcode = opc; ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;

        lu = exv && mr && idv && (ert != 4'd0) && ((ert == rs) || (urt && (ert == rt)));
        nl = m_left;
        if (!r) begin
            e.outs = O_RST; nl = 0;
        end else if (m_left > 1) begin
            e.outs = O_MDF; nl = m_left - 1;
        end else if (m_left == 1) begin
            e.outs = O_DONE; nl = 0;
        end else if (br) begin
            e.outs = O_BR;
        end else if (exv && opc == 4'hE) begin
            e.outs = O_MDF; nl = MDC - 1;
        end else if (lu) begin
            e.outs = O_LU;
        end else begin
            e.outs = O_NONE;
        end
`ifdef STALL_COUNT_EN
        e.cnt = 16'(m_stall);
`else
        e.cnt = 16'h0000;
`endif
        e.cnt_valid = r;
        e.tag = tag;
        ns = !r ? 0 : ((e.outs[6] && m_stall < 65535) ? m_stall + 1 : m_stall);
        exp_q.push_back(e);

        #2;
        got = exp_q.pop_front();
        check_eq({got.tag, ".outs"},
                 {25'd0, pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_bubble, exmem_bubble, md_done},
                 {25'd0, got.outs});
        if (got.cnt_valid) check_eq({got.tag, ".stall_cycles"}, {16'd0, stall_cycles}, {16'd0, got.cnt});
        if (r) check_eq({got.tag, ".freeze_xor_bubble"}, {31'd0, idex_freeze & idex_bubble}, 32'd0);

        @(posedge clk);
        m_left  = nl;
        m_stall = ns;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1, 0, 4'd0, 4'd0, 0, 0, 4'h0, 0, 4'd0, 0);
    endtask

    initial begin
        rest = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_valid = 0; ex_opcode = 0; ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;

        // Reset with an MD op sitting in EX
        cyc("rst0", 0, 1, 4'd1, 4'd2, 1, 1, 4'hE, 0, 4'd0, 0);
        cyc("rst1", 0, 1, 4'd1, 4'd2, 1, 1, 4'hE, 0, 4'd0, 0);
        idle("idle0");

        // Load-use on rs, then bubble in EX clears it
        cyc("lu_rs", 1, 1, 4'd3, 4'd7, 0, 1, 4'h9, 1, 4'd3, 0);
        cyc("lu_rs_after", 1, 1, 4'd3, 4'd7, 0, 0, 4'h0, 0, 4'd0, 0);
        cyc("lu_r0", 1, 1, 4'd0, 4'd7, 0, 1, 4'h9, 1, 4'd0, 0);

        // Load-use on rt gated by id_uses_rt
        cyc("lu_rt_unused", 1, 1, 4'd1, 4'd5, 0, 1, 4'h9, 1, 4'd5, 0);
        cyc("lu_rt_used", 1, 1, 4'd1, 4'd5, 1, 1, 4'h9, 1, 4'd5, 0);
        cyc("lu_idinv", 1, 0, 4'd5, 4'd5, 1, 1, 4'h9, 1, 4'd5, 0);
        cyc("md_exinv", 1, 0, 4'd0, 4'd0, 0, 0, 4'hE, 0, 4'd0, 0);

        // MD op: 3 frozen cycles then md_done; branch during busy ignored
        cyc("md_c0", 1, 1, 4'd2, 4'd3, 1, 1, 4'hE, 0, 4'd0, 0);
        cyc("md_c1", 1, 1, 4'd2, 4'd3, 1, 1, 4'hE, 0, 4'd0, 1);
        cyc("md_c2", 1, 1, 4'd2, 4'd3, 1, 1, 4'hE, 1, 4'd2, 0);
        cyc("md_c3", 1, 1, 4'd2, 4'd3, 1, 1, 4'hE, 0, 4'd0, 0);
        idle("md_after");

        // Branch and load-use together: flush only
        cyc("br_lu", 1, 1, 4'd6, 4'd0, 0, 1, 4'h9, 1, 4'd6, 1);
        idle("br_after");

        // Reset at md_cnt=2 aborts the op without md_done
        cyc("ab_c0", 1, 1, 4'd0, 4'd0, 0, 1, 4'hE, 0, 4'd0, 0);
        cyc("ab_c1", 1, 1, 4'd0, 4'd0, 0, 1, 4'hE, 0, 4'd0, 0);
        cyc("ab_rst", 0, 1, 4'd0, 4'd0, 0, 1, 4'hE, 0, 4'd0, 0);
        idle("ab_after");

        // Back-to-back MD ops
        for (int i = 0; i < 2 * MDC; i++)
            cyc($sformatf("b2b_%0d", i), 1, 1, 4'd1, 4'd1, 0, 1, 4'hE, 0, 4'd0, 0);
        idle("b2b_after");

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rs_r, rt_r, ert_r, opc_r;
            rs_r  = 4'($urandom_range(0, 3));
            rt_r  = 4'($urandom_range(0, 3));
            ert_r = 4'($urandom_range(0, 3));
            opc_r = ($urandom_range(0, 5) == 0) ? 4'hE : 4'h9;
            cyc($sformatf("rnd_%0d", i), ($urandom_range(0, 19) != 0), 1'($urandom), rs_r, rt_r,
                1'($urandom), 1'($urandom), opc_r, 1'($urandom), ert_r, ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
